// File: rtl/smem_fifo_pkg.sv
// Shared types and constants for the 2-write/1-read FIFO and its pair-packing feeder.
// The packer FSM only ever holds zero or one pending word, hence the two-state enum.
package smem_fifo_pkg;

    typedef enum logic {
        PK_EMPTY = 1'b0,
        PK_HALF  = 1'b1
    } pack_state_t;

    localparam int DEFAULT_DATA_WIDTH    = 65;
    localparam int DEFAULT_ADDRESS_WIDTH = 2;

    localparam logic [DEFAULT_DATA_WIDTH-1:0] PAD_DATA_DEFAULT = {DEFAULT_DATA_WIDTH{1'b0}};

    function automatic int credit_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_credit_counter.sv
// Free-word credit tracker for a FIFO without a full flag: minus two per pair write, plus one per read ack.
// An ack arriving while already at MAX (and no write) is a protocol violation and latches a sticky error.
module fifo_credit_counter #(
    parameter int MAX = 2,
    parameter int CW  = 3
) (
    input  logic          Clk,
    input  logic          Reset_in,
    input  logic          Issue2_in,
    input  logic          Ack_in,
    output logic [CW-1:0] Credits_out,
    output logic          Ge2_out,
    output logic          Overflow_err_out
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [CW-1:0] TWO_C = CW'(2);

    logic [CW-1:0] credits_q, credits_d;
    logic          ovf_q, ovf_d;

    // Next credit count and sticky overflow flag
    always_comb begin
        credits_d = credits_q;
        ovf_d     = ovf_q;
        if (Issue2_in && Ack_in) begin
            credits_d = credits_q - ONE_C;
        end else if (Issue2_in) begin
            credits_d = credits_q - TWO_C;
        end else if (Ack_in) begin
            if (credits_q == MAX_C) begin
                ovf_d = 1'b1;
            end else begin
                credits_d = credits_q + ONE_C;
            end
        end else begin
            credits_d = credits_q;
        end
    end

    // Credit and error registers
    always_ff @(posedge Clk or posedge Reset_in) begin
        if (Reset_in) begin
            credits_q <= MAX_C;
            ovf_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            ovf_q     <= ovf_d;
        end
    end

    assign Credits_out      = credits_q;
    assign Ge2_out          = (credits_q >= TWO_C);
    assign Overflow_err_out = ovf_q;

endmodule

// File: rtl/fifo_pair_packer.sv
// Packs a one-word-per-cycle valid/ready stream into word pairs for a 2-wide FIFO write port,
// padding a lone trailing word on flush or idle timeout and gating intake on FIFO credits.
module fifo_pair_packer
    import smem_fifo_pkg::*;
#(
    parameter int                    DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int                    ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int                    FIFO_DEPTH    = 1 << ADDRESS_WIDTH,
    parameter int                    FLUSH_TIMEOUT = 8,
    parameter logic [DATA_WIDTH-1:0] PAD_DATA      = {DATA_WIDTH{1'b0}},
    localparam int                   CW            = credit_width(FIFO_DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Reset_in,
    input  logic [DATA_WIDTH-1:0] In_data,
    input  logic                  In_valid,
    output logic                  In_ready,
    input  logic                  Flush_in,
    input  logic                  Read_ack_in,
    output logic [DATA_WIDTH-1:0] Data_out_1,
    output logic [DATA_WIDTH-1:0] Data_out_2,
    output logic                  WriteEn_out_2,
    output logic [CW-1:0]         Credits_out,
    output logic [15:0]           Pad_count_out,
    output logic                  Overflow_err_out
);

    localparam int             TW        = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]  TIMER_MAX = TW'(FLUSH_TIMEOUT);

    pack_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [DATA_WIDTH-1:0] data2_q, data2_d;
    logic                  wen_q, wen_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [15:0]           pad_cnt_q, pad_cnt_d;

    logic ge2_s;
    logic in_ready_s;
    logic accept_s;
    logic timeout_s;
    logic pad_s;
    logic issue_s;

    // Two words of headroom are reserved so the write pointer can never lap the read pointer.
    fifo_credit_counter #(
        .MAX (FIFO_DEPTH - 2),
        .CW  (CW)
    ) u_credits (
        .Clk              (Clk),
        .Reset_in         (Reset_in),
        .Issue2_in        (issue_s),
        .Ack_in           (Read_ack_in),
        .Credits_out      (Credits_out),
        .Ge2_out          (ge2_s),
        .Overflow_err_out (Overflow_err_out)
    );

    assign in_ready_s = !Reset_in && ((state_q == PK_EMPTY) || ge2_s);
    assign accept_s   = In_valid && in_ready_s;
    assign timeout_s  = (FLUSH_TIMEOUT != 0) && (timer_q == TIMER_MAX);
    assign pad_s      = (state_q == PK_HALF) && !accept_s && (Flush_in || timeout_s) && ge2_s;
    assign issue_s    = ((state_q == PK_HALF) && accept_s) || pad_s;

    // Packing FSM: a real partner word always wins over a flush or timeout pad
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        wen_d     = 1'b0;
        timer_d   = timer_q;
        pad_cnt_d = pad_cnt_q;
        case (state_q)
            PK_EMPTY: begin
                timer_d = {TW{1'b0}};
                if (accept_s) begin
                    hold_d  = In_data;
                    state_d = PK_HALF;
                end else begin
                    state_d = PK_EMPTY;
                end
            end
            PK_HALF: begin
                if (accept_s) begin
                    data1_d = hold_q;
                    data2_d = In_data;
                    wen_d   = 1'b1;
                    timer_d = {TW{1'b0}};
                    state_d = PK_EMPTY;
                end else if (pad_s) begin
                    data1_d = hold_q;
                    data2_d = PAD_DATA;
                    wen_d   = 1'b1;
                    timer_d = {TW{1'b0}};
                    state_d = PK_EMPTY;
                    if (pad_cnt_q != 16'hFFFF) begin
                        pad_cnt_d = pad_cnt_q + 16'd1;
                    end else begin
                        pad_cnt_d = pad_cnt_q;
                    end
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + TW'(1);
                end else begin
                    timer_d = timer_q;
                end
            end
            default: begin
                state_d = PK_EMPTY;
                timer_d = {TW{1'b0}};
            end
        endcase
    end

    // State, hold, timer and output registers
    always_ff @(posedge Clk or posedge Reset_in) begin
        if (Reset_in) begin
            state_q   <= PK_EMPTY;
            hold_q    <= {DATA_WIDTH{1'b0}};
            data1_q   <= {DATA_WIDTH{1'b0}};
            data2_q   <= {DATA_WIDTH{1'b0}};
            wen_q     <= 1'b0;
            timer_q   <= {TW{1'b0}};
            pad_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            wen_q     <= wen_d;
            timer_q   <= timer_d;
            pad_cnt_q <= pad_cnt_d;
        end
    end

    assign In_ready      = in_ready_s;
    assign Data_out_1    = data1_q;
    assign Data_out_2    = data2_q;
    assign WriteEn_out_2 = wen_q;
    assign Pad_count_out = pad_cnt_q;

endmodule
